// File: rtl/tdma_tx_scheduler.sv
// TDMA transmit scheduler: slot timer, SOS/data arbitration, carrier sense with backoff and retry.
// Optional macro TX_GUARD_EN forbids starting a transmission in the last GUARD_CYCLES of the slot.
module tdma_tx_scheduler #(
  parameter int WORD_WIDTH     = 16,
  parameter int SLOT_CYCLES    = 64,
  parameter int NUM_SLOTS      = 16,
  parameter int BACKOFF_CYCLES = 4,
  parameter int MAX_RETRY      = 3,
  parameter int GUARD_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] myTimeslot,
  input  logic                  req_data,
  input  logic                  req_sos,
  input  logic                  channel_clear,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [2:0]            tx_type,
  output logic                  done_data,
  output logic                  done_sos,
  output logic                  drop,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] slot_idx,
  output logic                  slot_tick
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [2:0] T_DATA = 3'b101;
  localparam logic [2:0] T_SOS  = 3'b110;
`ifdef TX_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WAIT_SLOT, SENSE, BACKOFF, TX} state_t;

  state_t          state, nxt;
  logic [CW-1:0]   cyc_cnt;
  logic            run;
  logic            pend_data, pend_sos;
  logic            typ_sos, sos_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [BW-1:0]   boff, boff_nxt;
  logic            cyc_last, slot_last, guard_ok;

  assign cyc_last  = (cyc_cnt == CW'(SLOT_CYCLES - 1));
  assign slot_last = (slot_idx == WORD_WIDTH'(NUM_SLOTS - 1));
  assign guard_ok  = !GUARD_ON || (cyc_cnt <= CW'(SLOT_CYCLES - 1 - GUARD_CYCLES));

  // run holds the counter at 0 for the first post-reset cycle so that cycle carries the first tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      slot_idx  <= '0;
      slot_tick <= 1'b0;
      run       <= 1'b0;
    end else if (!run) begin
      run       <= 1'b1;
      slot_tick <= 1'b1;
    end else if (cyc_last) begin
      cyc_cnt   <= '0;
      slot_tick <= 1'b1;
      slot_idx  <= slot_last ? '0 : slot_idx + 1'b1;
    end else begin
      cyc_cnt   <= cyc_cnt + 1'b1;
      slot_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      typ_sos   <= 1'b0;
      retry     <= '0;
      boff      <= '0;
      pend_data <= 1'b0;
      pend_sos  <= 1'b0;
    end else begin
      state     <= nxt;
      typ_sos   <= sos_nxt;
      retry     <= retry_nxt;
      boff      <= boff_nxt;
      // A fresh request in the same cycle as the clear is kept rather than lost.
      pend_data <= req_data | (pend_data & ~(done_data | (drop & ~typ_sos)));
      pend_sos  <= req_sos  | (pend_sos  & ~(done_sos  | (drop &  typ_sos)));
    end
  end

  always_comb begin
    nxt       = state;
    sos_nxt   = typ_sos;
    retry_nxt = retry;
    boff_nxt  = boff;
    tx_start  = 1'b0;
    done_data = 1'b0;
    done_sos  = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_sos || pend_data) begin
          sos_nxt   = pend_sos;
          retry_nxt = '0;
          nxt       = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (slot_tick && (slot_idx == myTimeslot)) nxt = SENSE;
      end
      SENSE: begin
        if (channel_clear && guard_ok) begin
          tx_start = 1'b1;
          nxt      = TX;
        end else begin
          boff_nxt = BW'(BACKOFF_CYCLES - 1);
          nxt      = BACKOFF;
        end
      end
      BACKOFF: begin
        if (boff == '0) nxt = SENSE;
        else boff_nxt = boff - 1'b1;
      end
      TX: begin
        if (tx_done) begin
          done_sos  = typ_sos;
          done_data = !typ_sos;
          nxt       = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
    // Slot ran out without a start: count the attempt, give up after MAX_RETRY slots.
    if ((state == SENSE || state == BACKOFF) && cyc_last && !tx_start) begin
      retry_nxt = retry + 1'b1;
      if (retry == RW'(MAX_RETRY - 1)) begin
        drop = 1'b1;
        nxt  = IDLE;
      end else begin
        nxt  = WAIT_SLOT;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign tx_type = (state == IDLE) ? 3'b000 : (typ_sos ? T_SOS : T_DATA);

endmodule

// File: tb/tb_tdma_tx_scheduler.sv
// Scoreboard bench for tdma_tx_scheduler: stimulus queues expected pulses, a monitor pops and checks them.
module tb_tdma_tx_scheduler;
  localparam int WW = 16;
  localparam int SC = 64;
  localparam int NS = 16;
  localparam int FR = SC * NS;
  localparam int K_TXS = 0, K_DD = 1, K_DS = 2, K_DROP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] myTimeslot = '0;
  logic          req_data = 1'b0, req_sos = 1'b0, channel_clear = 1'b0, tx_done = 1'b0;
  logic          tx_start, done_data, done_sos, drop, busy, slot_tick;
  logic [2:0]    tx_type;
  logic [WW-1:0] slot_idx;

  typedef struct {int kind; int t; logic [2:0] ty;} exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int tcyc  = -1;

  tdma_tx_scheduler #(.WORD_WIDTH(WW), .SLOT_CYCLES(SC), .NUM_SLOTS(NS),
                      .BACKOFF_CYCLES(4), .MAX_RETRY(3), .GUARD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .myTimeslot(myTimeslot), .req_data(req_data), .req_sos(req_sos),
    .channel_clear(channel_clear), .tx_done(tx_done), .tx_start(tx_start), .tx_type(tx_type),
    .done_data(done_data), .done_sos(done_sos), .drop(drop), .busy(busy),
    .slot_idx(slot_idx), .slot_tick(slot_tick));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tcyc <= -1;
    else     tcyc <= tcyc + 1;
  end

  task automatic check_pulse(input int k);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_pulse kind=%0d at t=%0d (nothing expected)", k, tcyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.t != tcyc || e.ty !== tx_type) begin
        n_err++;
        $display("FAIL pulse got kind=%0d t=%0d type=%b, want kind=%0d t=%0d type=%b",
                 k, tcyc, tx_type, e.kind, e.t, e.ty);
      end
    end
  endtask

  // Monitor: slot timer model every cycle, pulses checked against the queue.
  always @(negedge clk) begin
    if (!rst && tcyc >= 0) begin
      n_cmp++;
      if (slot_tick !== ((tcyc % SC) == 0) || slot_idx !== WW'((tcyc / SC) % NS)) begin
        n_err++;
        $display("FAIL slot_timer t=%0d got tick=%b idx=%0d, want tick=%b idx=%0d",
                 tcyc, slot_tick, slot_idx, ((tcyc % SC) == 0), (tcyc / SC) % NS);
      end
      if (tx_start)  check_pulse(K_TXS);
      if (done_data) check_pulse(K_DD);
      if (done_sos)  check_pulse(K_DS);
      if (drop)      check_pulse(K_DROP);
    end
  end

  task automatic push(input int k, input int t, input logic [2:0] ty);
    exp_t e;
    e.kind = k; e.t = t; e.ty = ty;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (tcyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_at(input int t, input bit d, input bit s, input bit dn);
    wait_until(t);
    req_data = d; req_sos = s; tx_done = dn;
    @(posedge clk); #1;
    req_data = 1'b0; req_sos = 1'b0; tx_done = 1'b0;
  endtask

  // Reset for a few cycles; every output must read 0 and no expected pulse may be left over.
  task automatic do_reset();
    rst = 1'b1; req_data = 1'b0; req_sos = 1'b0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({tx_start, tx_type, done_data, done_sos, drop, busy, slot_tick, slot_idx}), 0);
    chk("leftover_expected", q.size(), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int t_g;

  initial begin
    // 1: idle for two frames, timer checked by monitor, nothing else moves.
    do_reset();
    wait_until(2 * FR + 3);
    chk("idle_busy", int'(busy), 0);
    chk("idle_type", int'(tx_type), 0);

    // 2: single data packet in slot 3; stray tx_done while waiting is ignored.
    do_reset();
    myTimeslot = 3; channel_clear = 1'b1;
    push(K_TXS, 193, 3'b101);
    push(K_DD,  203, 3'b101);
    pulse_at(5, 1, 0, 0);
    pulse_at(100, 0, 0, 1);
    wait_until(150);
    chk("wait_busy", int'(busy), 1);
    chk("wait_type", int'(tx_type), 5);
    pulse_at(203, 0, 0, 1);
    chk("after_done_busy", int'(busy), 0);
    chk("after_done_type", int'(tx_type), 0);

    // 3: SOS wins the tie, data next frame, a late SOS waits behind the data.
    do_reset();
    myTimeslot = 2; channel_clear = 1'b1;
    push(K_TXS, 129, 3'b110);
    push(K_DS,  135, 3'b110);
    push(K_TXS, 1153, 3'b101);
    push(K_DD,  1160, 3'b101);
    push(K_TXS, 2177, 3'b110);
    push(K_DS,  2184, 3'b110);
    pulse_at(3, 1, 1, 0);
    pulse_at(135, 0, 0, 1);
    pulse_at(140, 0, 1, 0);
    wait_until(600);
    chk("data_wait_type", int'(tx_type), 5);
    pulse_at(1160, 0, 0, 1);
    pulse_at(2184, 0, 0, 1);

    // 4: busy channel, two backoffs, start on the third sense.
    do_reset();
    myTimeslot = 1; channel_clear = 1'b0;
    push(K_TXS, 75, 3'b101);
    push(K_DD,  80, 3'b101);
    pulse_at(2, 1, 0, 0);
    wait_until(73);
    channel_clear = 1'b1;
    pulse_at(80, 0, 0, 1);

    // 5: channel never clears: drop at the end of the third own slot, flag cleared.
    do_reset();
    myTimeslot = 1; channel_clear = 1'b0;
    push(K_DROP, 2 * FR + SC + SC - 1, 3'b101);
    pulse_at(2, 1, 0, 0);
    wait_until(FR + 10);
    chk("retry_busy", int'(busy), 1);
    wait_until(2 * FR + 2 * SC + 5);
    chk("drop_busy", int'(busy), 0);
    chk("drop_type", int'(tx_type), 0);

    // 6: channel clears late in the slot (guarded build defers to next frame).
    do_reset();
    myTimeslot = 1; channel_clear = 1'b0;
`ifdef TX_GUARD_EN
    t_g = FR + 65;
`else
    t_g = 125;
`endif
    push(K_TXS, t_g, 3'b101);
    push(K_DD,  t_g + 5, 3'b101);
    pulse_at(2, 1, 0, 0);
    wait_until(124);
    channel_clear = 1'b1;
    pulse_at(t_g + 5, 0, 0, 1);

    // 7: out-of-range slot waits forever; reset mid-attempt aborts silently.
    do_reset();
    myTimeslot = 20; channel_clear = 1'b1;
    pulse_at(2, 1, 0, 0);
    wait_until(FR + 80);
    chk("oor_busy", int'(busy), 1);
    do_reset();
    wait_until(10);
    chk("post_abort_busy", int'(busy), 0);

    rst = 1'b1;
    @(negedge clk);
    chk("final_leftover", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
